// File: rtl/ifsram_r.sv
// ifmap SRAM reader: issues 3x3 sliding-window reads (kernel column, row, column window)
// and streams the returned words through a 4-entry valid/ready output FIFO.
module ifsram_r #(
   parameter int TBITS     = 64,
   parameter int ROW_WORDS = 64,
   parameter int KSIZE     = 3,
   parameter int ADDR_BITS = 11
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start_if_read,
   output logic                 if_read_busy,
   output logic                 if_read_done,
   output logic                 cen_ifsram,
   output logic                 wen_ifsram,
   output logic [ADDR_BITS-1:0] addr_ifsram,
   input  logic [TBITS-1:0]     q_ifsram,
   output logic [TBITS-1:0]     ifmap_data,
   output logic                 ifmap_valid,
   input  logic                 ifmap_ready,
   output logic                 ifmap_last,
   output logic [5:0]           ifmap_col
);

   localparam int NCOL  = ROW_WORDS - KSIZE + 1;
   localparam int KW    = (KSIZE > 1) ? $clog2(KSIZE) : 1;
   localparam int CW    = 6;
   localparam int DEPTH = 4;
   localparam logic [KW-1:0] K_LAST = KW'(KSIZE - 1);
   localparam logic [CW-1:0] C_LAST = CW'(NCOL - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                 r_state;
   logic                   r_busy, r_done, r_cen;
   logic [ADDR_BITS-1:0]   r_addr;
   logic [KW-1:0]          r_kc, r_r;
   logic [CW-1:0]          r_c;
   logic                   r_inflight;
   logic                   r_iss_last, r_inf_last;
   logic [CW-1:0]          r_iss_col, r_inf_col;

   logic [TBITS-1:0]       r_mem_data [DEPTH];
   logic                   r_mem_last [DEPTH];
   logic [CW-1:0]          r_mem_col  [DEPTH];
   logic [1:0]             r_wr_ptr, r_rd_ptr;
   logic [2:0]             r_count;

   logic                   w_issue_now, w_push, w_pop, w_first, w_issue_nxt, w_final;
   logic [2:0]             w_count_nxt, w_occ_nxt;
   logic [KW-1:0]          w_kc, w_r;
   logic [CW-1:0]          w_c;
   logic [ADDR_BITS-1:0]   w_addr;

   // cen/addr are registered, so the issue decision for the next cycle looks at next-cycle occupancy.
   assign w_issue_now = ~r_cen;
   assign w_push      = r_inflight;
   assign w_pop       = ifmap_valid & ifmap_ready;
   assign w_count_nxt = r_count + {2'b00, w_push} - {2'b00, w_pop};
   assign w_occ_nxt   = w_count_nxt + {2'b00, w_issue_now};
   assign w_first     = (r_state == S_IDLE) & start_if_read;
   assign w_issue_nxt = ((r_state == S_RUN) | w_first) & (w_occ_nxt <= 3'd2);

   assign w_kc    = w_first ? '0 : r_kc;
   assign w_r     = w_first ? '0 : r_r;
   assign w_c     = w_first ? '0 : r_c;
   assign w_final = (w_c == C_LAST) & (w_r == K_LAST) & (w_kc == K_LAST);
   assign w_addr  = ADDR_BITS'(ROW_WORDS) * ADDR_BITS'(w_r) + ADDR_BITS'(w_c) + ADDR_BITS'(w_kc);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_cen      <= 1'b1;
         r_addr     <= '0;
         r_kc       <= '0;
         r_r        <= '0;
         r_c        <= '0;
         r_inflight <= 1'b0;
         r_iss_last <= 1'b0;
         r_iss_col  <= '0;
         r_inf_last <= 1'b0;
         r_inf_col  <= '0;
      end else begin
         r_inflight <= w_issue_now;
         r_inf_last <= r_iss_last;
         r_inf_col  <= r_iss_col;
         r_cen      <= ~w_issue_nxt;
         r_done     <= 1'b0;

         case (r_state)
            S_IDLE: if (start_if_read) begin
               r_state <= (w_issue_nxt & w_final) ? S_DRAIN : S_RUN;
               r_busy  <= 1'b1;
               r_kc    <= '0;
               r_r     <= '0;
               r_c     <= '0;
            end
            S_RUN: if (w_issue_nxt & w_final) r_state <= S_DRAIN;
            S_DRAIN: if ((w_count_nxt == 3'd0) & ~w_issue_now) begin
               r_state <= S_DONE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase

         // Counters advance only on issue; this overrides the clear on the start cycle.
         if (w_issue_nxt) begin
            r_addr     <= w_addr;
            r_iss_last <= (w_r == K_LAST) & (w_kc == K_LAST);
            r_iss_col  <= w_c;
            if (w_kc == K_LAST) begin
               r_kc <= '0;
               if (w_r == K_LAST) begin
                  r_r <= '0;
                  r_c <= w_c + CW'(1);
               end else begin
                  r_r <= w_r + KW'(1);
               end
            end else begin
               r_kc <= w_kc + KW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
         r_count <= w_count_nxt;
      end
   end

   // FIFO storage needs no reset: every entry is written before the count exposes it.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_data[r_wr_ptr] <= q_ifsram;
         r_mem_last[r_wr_ptr] <= r_inf_last;
         r_mem_col[r_wr_ptr]  <= r_inf_col;
      end
   end

   assign if_read_busy = r_busy;
   assign if_read_done = r_done;
   assign cen_ifsram   = r_cen;
   assign wen_ifsram   = 1'b1;
   assign addr_ifsram  = r_addr;
   assign ifmap_valid  = (r_count != 3'd0);
   assign ifmap_data   = r_mem_data[r_rd_ptr];
   assign ifmap_last   = ifmap_valid & r_mem_last[r_rd_ptr];
   assign ifmap_col    = ifmap_valid ? r_mem_col[r_rd_ptr] : '0;

endmodule

// File: tb/tb_ifsram_r.sv
// Self-checking bench for ifsram_r: a window-order reference model plus an SRAM model,
// compared against the DUT every cycle under full-rate, random and stalled backpressure.
module tb_ifsram_r;

   localparam int TBITS = 64, ROW_WORDS = 64, KSIZE = 3, ADDR_BITS = 11;
   localparam int NCOL  = ROW_WORDS - KSIZE + 1;
   localparam int TOTAL = NCOL * KSIZE * KSIZE;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 start_if_read = 1'b0;
   logic                 if_read_busy, if_read_done, cen_ifsram, wen_ifsram;
   logic [ADDR_BITS-1:0] addr_ifsram;
   logic [TBITS-1:0]     q_ifsram = '0;
   logic [TBITS-1:0]     ifmap_data;
   logic                 ifmap_valid;
   logic                 ifmap_ready = 1'b1;
   logic                 ifmap_last;
   logic [5:0]           ifmap_col;

   ifsram_r #(.TBITS(TBITS), .ROW_WORDS(ROW_WORDS), .KSIZE(KSIZE), .ADDR_BITS(ADDR_BITS)) dut (
      .clk(clk), .reset(reset), .start_if_read(start_if_read),
      .if_read_busy(if_read_busy), .if_read_done(if_read_done),
      .cen_ifsram(cen_ifsram), .wen_ifsram(wen_ifsram), .addr_ifsram(addr_ifsram),
      .q_ifsram(q_ifsram), .ifmap_data(ifmap_data), .ifmap_valid(ifmap_valid),
      .ifmap_ready(ifmap_ready), .ifmap_last(ifmap_last), .ifmap_col(ifmap_col)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: bound expired (t=%0t)", name, $time);
   endtask

   // Expected window order, built straight from the nested-loop rule.
   int   exp_addr [TOTAL];
   int   exp_col  [TOTAL];
   logic exp_last [TOTAL];
   initial begin
      int i;
      i = 0;
      for (int c = 0; c < NCOL; c++)
         for (int r = 0; r < KSIZE; r++)
            for (int kc = 0; kc < KSIZE; kc++) begin
               exp_addr[i] = r * ROW_WORDS + c + kc;
               exp_col[i]  = c;
               exp_last[i] = (r == KSIZE - 1) && (kc == KSIZE - 1);
               i++;
            end
   end

   // SRAM model: word[a] = a, data one cycle after a chip-enabled read.
   always @(posedge clk) if (!cen_ifsram) q_ifsram <= TBITS'(addr_ifsram);

   int cyc = 0;
   always @(posedge clk) cyc++;

   // Ready pattern: 0 = held high, 1 = random 50%, 2 = held low.
   int rmode = 0;
   always @(posedge clk) begin
      #1;
      case (rmode)
         0:       ifmap_ready = 1'b1;
         1:       ifmap_ready = 1'($urandom % 2);
         default: ifmap_ready = 1'b0;
      endcase
   end

   // Reference model state.
   logic             m_busy = 0, m_done = 0;
   int               m_iss = 0, m_xfer = 0, iss_prev = 0;
   int               done_cnt = 0, start_cyc = 0, first_valid_cyc = 0, done_cyc = 0;
   logic             seen_valid = 0;
   logic             stall_prev = 0;
   logic [TBITS-1:0] prev_data;
   logic             prev_last;
   logic [5:0]       prev_col;
   logic [TBITS-1:0] got_data [TOTAL];
   logic [5:0]       got_col  [TOTAL];
   logic             got_last [TOTAL];

   always @(negedge clk) begin
      if (reset) begin
         m_busy = 0; m_done = 0; m_iss = 0; m_xfer = 0; iss_prev = 0;
         stall_prev = 0; seen_valid = 0;
      end else begin
         int   iss_start;
         logic final_now;
         iss_start = m_iss;
         final_now = 0;

         check("busy", if_read_busy, m_busy);
         check("done", if_read_done, m_done);
         if (if_read_done) begin
            done_cnt++;
            done_cyc = cyc;
         end

         // Words in the FIFO = reads issued two or more cycles ago minus words transferred.
         check("valid", ifmap_valid, iss_prev > m_xfer);
         check("occupancy_le4", (iss_prev - m_xfer) <= 4, 1);

         if (!cen_ifsram) begin
            check("issue_only_busy", m_busy, 1);
            check("cen_rule", (m_iss - m_xfer) <= 2, 1);
            if (m_iss < TOTAL) check("addr", addr_ifsram, exp_addr[m_iss]);
            else fail_now("extra_issue");
            m_iss++;
         end

         if (stall_prev) begin
            check("hold_valid", ifmap_valid, 1);
            check("hold_data", ifmap_data, prev_data);
            check("hold_last", ifmap_last, prev_last);
            check("hold_col", ifmap_col, prev_col);
         end

         if (ifmap_valid && !seen_valid) begin
            seen_valid = 1;
            first_valid_cyc = cyc;
         end

         if (ifmap_valid && ifmap_ready) begin
            if (m_xfer < TOTAL) begin
               check("data", ifmap_data, TBITS'(exp_addr[m_xfer]));
               check("last", ifmap_last, exp_last[m_xfer]);
               check("col", ifmap_col, exp_col[m_xfer]);
               got_data[m_xfer] = ifmap_data;
               got_col[m_xfer]  = ifmap_col;
               got_last[m_xfer] = ifmap_last;
               final_now = (m_xfer == TOTAL - 1);
            end else begin
               fail_now("extra_word");
            end
            m_xfer++;
         end

         stall_prev = ifmap_valid && !ifmap_ready;
         prev_data  = ifmap_data;
         prev_last  = ifmap_last;
         prev_col   = ifmap_col;

         // Next-cycle expectation: idle -> active on start, active until final transfer, one done cycle.
         if (m_done) begin
            m_done = 0;
         end else if (m_busy) begin
            if (final_now) begin
               m_busy = 0;
               m_done = 1;
            end
         end else if (start_if_read) begin
            m_busy = 1; m_iss = 0; m_xfer = 0; iss_start = 0;
            seen_valid = 0;
            start_cyc = cyc;
         end
         iss_prev = iss_start;
      end
   end

   task automatic do_start();
      @(posedge clk); #1 start_if_read = 1'b1;
      @(posedge clk); #1 start_if_read = 1'b0;
   endtask

   task automatic wait_done(input int bound, input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (!if_read_done && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (!if_read_done) fail_now(tag);
      #1;
   endtask

   // Hand-computed pins on the model and on full-rate timing.
   task automatic check_pass(input logic full_rate);
      int first9 [9];
      first9 = '{0, 1, 2, 64, 65, 66, 128, 129, 130};
      for (int i = 0; i < 9; i++) begin
         check("first9_data", got_data[i], first9[i]);
         check("first9_col", got_col[i], 0);
      end
      check("first_last0", got_last[0], 0);
      check("ninth_last", got_last[8], 1);
      check("tenth_col", got_col[9], 1);
      check("final_data", got_data[TOTAL-1], 191);
      check("final_col", got_col[TOTAL-1], 61);
      check("final_last", got_last[TOTAL-1], 1);
      if (full_rate) begin
         check("first_valid_latency", first_valid_cyc - start_cyc, 3);
         check("done_latency", done_cyc - start_cyc, 561);
      end
   endtask

   initial begin
      int d0;
      #12;
      check("rst_busy", if_read_busy, 0);
      check("rst_done", if_read_done, 0);
      check("rst_cen", cen_ifsram, 1);
      check("rst_wen", wen_ifsram, 1);
      check("rst_addr", addr_ifsram, 0);
      check("rst_valid", ifmap_valid, 0);
      check("rst_last", ifmap_last, 0);
      check("rst_col", ifmap_col, 0);
      #4 reset = 1'b0;

      // Full rate, then a back-to-back second pass started the cycle after done.
      rmode = 0;
      d0 = done_cnt;
      do_start();
      wait_done(700, "done_pass1");
      check_pass(1);
      do_start();
      wait_done(700, "done_pass2");
      check_pass(1);
      check("done_count_b2b", done_cnt - d0, 2);

      // Random 50% backpressure.
      rmode = 1;
      do_start();
      wait_done(4000, "done_random");
      check_pass(0);

      // Ready held low: three reads then stall; release; stray start mid-stream.
      rmode = 2;
      d0 = done_cnt;
      do_start();
      repeat (20) @(posedge clk);
      @(negedge clk); #1;
      check("stall_issues", m_iss, 3);
      check("stall_cen", cen_ifsram, 1);
      check("stall_words_held", m_xfer, 0);
      rmode = 1;
      repeat (100) @(posedge clk);
      do_start();
      wait_done(4000, "done_restart_ignored");
      check_pass(0);
      repeat (10) @(posedge clk);
      check("single_done", done_cnt - d0, 1);

      // Asynchronous reset mid-run at word 200, then a fresh full-rate pass.
      rmode = 0;
      do_start();
      begin
         int n;
         n = 0;
         while (m_xfer < 200 && n < 1000) begin
            @(negedge clk);
            n++;
         end
         if (m_xfer < 200) fail_now("reach_word200");
      end
      @(posedge clk); #3 reset = 1'b1;
      #1;
      check("async_valid", ifmap_valid, 0);
      check("async_busy", if_read_busy, 0);
      check("async_cen", cen_ifsram, 1);
      check("async_last", ifmap_last, 0);
      check("async_col", ifmap_col, 0);
      @(posedge clk); @(posedge clk); #1 reset = 1'b0;
      do_start();
      wait_done(700, "done_after_reset");
      check_pass(1);

      repeat (5) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ifsram_r.md
# ifsram_r

Reads the ifmap SRAM filled by the ifmap store stage and streams 3x3 sliding-window words to the PE feeder. Read order: column-window, then row, then kernel column. Output uses a valid/ready handshake, buffered by a 4-entry output FIFO so backpressure never drops SRAM read data. It sits directly downstream of the ifmap SRAM write stage and is started by get_ins after `if_store_done`.

## Interface

- `TBITS`, 64, SRAM word / output data width
- `ROW_WORDS`, 64, words per stored row (row r occupies addresses r*ROW_WORDS .. r*ROW_WORDS+ROW_WORDS-1)
- `KSIZE`, 3, kernel height/width; also the number of stored rows
- `ADDR_BITS`, 11, SRAM address width

- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `start_if_read`  in  1  start request from get_ins; sampled only in IDLE
- `if_read_busy`  out  1  high in RUN and DRAIN
- `if_read_done`  out  1  one-cycle pulse in DONE
- `cen_ifsram`  out  1  SRAM chip enable, active-low
- `wen_ifsram`  out  1  SRAM write enable, active-low; tied high (read only)
- `addr_ifsram`  out  ADDR_BITS  SRAM read address
- `q_ifsram`  in  TBITS  SRAM read data, valid the cycle after `cen_ifsram` low
- `ifmap_data`  out  TBITS  window word (FIFO head)
- `ifmap_valid`  out  1  FIFO non-empty
- `ifmap_ready`  in  1  consumer accepts; transfer when valid&ready
- `ifmap_last`  out  1  head word is the last (9th) word of its column window
- `ifmap_col`  out  6  column-window index of the head word

## Operation

- Window count NCOL = ROW_WORDS-KSIZE+1 (62). Words per window = KSIZE*KSIZE (9). Total = 558.
- Read sequence uses nested counters:
  - kc (innermost), 0..KSIZE-1
  - r, 0..KSIZE-1
  - c (outermost), 0..NCOL-1
  - Address = r*ROW_WORDS + c + kc, computed at ADDR_BITS width; max is 2*64+61+2 = 191.
- FSM states and transitions:
  - IDLE: goes to RUN on `start_if_read`.
  - RUN: issues reads. After the last address (c=NCOL-1, r=kc=KSIZE-1) is issued, goes to DRAIN.
  - DRAIN: no issue. Goes to DONE when FIFO is empty, no read is in flight, and the final word has handshaken.
  - DONE: lasts one cycle, then goes to IDLE.
- Issue rule in RUN: `cen_ifsram`=0 when fifo_count + inflight <= 2, where inflight is 1 if a read was issued last cycle. Counters advance only on issue.
- Read data handling: `q_ifsram` is pushed into the FIFO in the cycle after issue, together with a tag {last = (r==KSIZE-1 && kc==KSIZE-1), col = c}. Data is never dropped; the issue rule guarantees FIFO depth 4 is never exceeded.
- FIFO pop on `ifmap_valid & ifmap_ready`. A push and a pop in the same cycle leave the count unchanged.
- `start_if_read` outside IDLE is ignored. Counters clear when entering RUN.
- Reset is asynchronous and applies in any state. All outputs take their reset values immediately; the FIFO and all counters clear.

## Timing

- Reset values:
  - `if_read_busy`=0, `if_read_done`=0
  - `cen_ifsram`=1, `wen_ifsram`=1, `addr_ifsram`=0
  - `ifmap_valid`=0, `ifmap_last`=0, `ifmap_col`=0
  - `ifmap_data` is don't-care while `ifmap_valid`=0.
- Latency: `start_if_read` high in cycle T causes:
  - RUN and first issue (addr 0) in T+1
  - `q_ifsram` valid in T+2
  - `ifmap_valid`=1 in T+3
- Throughput: with `ifmap_ready` held high, one word is issued and one delivered per cycle. The final word is transferred at T+560 and `if_read_done` pulses at T+561.
- `addr_ifsram` holds its last value while `cen_ifsram`=1.
- `ifmap_valid` never drops without a handshake. `ifmap_data`, `ifmap_last` and `ifmap_col` stay stable while valid is high and ready is low.

## Test plan

- Reset, then start with ready=1 and SRAM preloaded with word[a]=a. Expect 558 words in order:
  - first nine: 0,1,2,64,65,66,128,129,130 with col=0
  - `ifmap_last` on every 9th word
  - last word 191 with col=61
  - `if_read_done` pulse 561 cycles after start.
- Toggle ready randomly (50%). Expect the identical sequence with no loss or duplication, FIFO occupancy never above 4, and `cen_ifsram` low only when fifo_count + inflight <= 2.
- Hold ready=0 after start. Expect exactly 3 reads issued, then `cen_ifsram` held high. When ready is released, the stream resumes with the next expected word.
- Pulse start again while busy, mid-stream. Expect no effect on the sequence or counters, and one done pulse only.
- Assert reset asynchronously mid-RUN, at word 200. Expect immediate `ifmap_valid`=0, busy=0, cen=1. A fresh start restarts from address 0.
- Issue back-to-back starts, with the second start in the cycle after DONE. Expect the second pass to be identical to the first.
